// File: rtl/i2c_slave_reg_ctrl_if.sv
// i2c_slave_reg_ctrl_if: byte-side (i2c slave) and register-bus signals of the register controller
interface i2c_slave_reg_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        as_data_i;
    logic              as_dstrb_i;
    logic              as_busy_i;
    logic              i2c_cmnd_strb_i;
    logic [7:0]        as_data_o;
    logic              as_dstrb_o;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wr_data;
    logic              bus_wr_strb;
    logic              bus_rd_strb;
    logic [7:0]        bus_rd_data;
    logic              bus_ack;
    logic [ADDR_W-1:0] ptr_o;
    logic              err_o;

    modport master (
        input  as_data_i, as_dstrb_i, as_busy_i, i2c_cmnd_strb_i, bus_rd_data, bus_ack,
        output as_data_o, as_dstrb_o, bus_addr, bus_wr_data, bus_wr_strb, bus_rd_strb, ptr_o, err_o
    );

    modport slave (
        output as_data_i, as_dstrb_i, as_busy_i, i2c_cmnd_strb_i, bus_rd_data, bus_ack,
        input  as_data_o, as_dstrb_o, bus_addr, bus_wr_data, bus_wr_strb, bus_rd_strb, ptr_o, err_o
    );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// i2c_slave_reg_ctrl: register-pointer sequencer between an i2c slave byte interface and an 8-bit register bus
module i2c_slave_reg_ctrl #(
    parameter int         ADDR_W     = 8,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] RD_DEFAULT = 8'hFF
) (
    input logic                  clk,
    input logic                  reset,
    i2c_slave_reg_ctrl_if.master sif
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, LOAD, WR_REQ, WR_WAIT} state_t;

    state_t            state_q, state_d;
    logic              first_byte_q, first_byte_d;
    logic              loaded_q, loaded_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [7:0]        as_data_q, as_data_d;
    logic              as_dstrb_q, as_dstrb_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]        bus_wr_data_q, bus_wr_data_d;
    logic              bus_wr_strb_q, bus_wr_strb_d;
    logic              bus_rd_strb_q, bus_rd_strb_d;
    logic              consumed;

    assign consumed = busy_q & ~sif.as_busy_i & loaded_q;

    // FSM sequencing first, then byte-side events layered on top so new requests are never lost
    always_comb begin
        state_d       = state_q;
        first_byte_d  = first_byte_q;
        loaded_d      = loaded_q;
        wr_pend_d     = wr_pend_q;
        rd_pend_d     = rd_pend_q;
        busy_d        = sif.as_busy_i;
        ptr_d         = ptr_q;
        wr_data_d     = wr_data_q;
        rd_data_d     = rd_data_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        as_data_d     = as_data_q;
        as_dstrb_d    = 1'b0;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_wr_strb_d = bus_wr_strb_q;
        bus_rd_strb_d = bus_rd_strb_q;
        case (state_q)
            IDLE: state_d = wr_pend_q ? WR_REQ : rd_pend_q ? RD_REQ : IDLE;
            WR_REQ: begin
                bus_addr_d    = ptr_q;
                bus_wr_data_d = wr_data_q;
                bus_wr_strb_d = 1'b1;
                cnt_d         = CW'(TIMEOUT);
                state_d       = WR_WAIT;
            end
            WR_WAIT: begin
                if (sif.bus_ack || cnt_q == '0) begin
                    bus_wr_strb_d = 1'b0;
                    ptr_d         = ptr_q + 1'b1;
                    wr_pend_d     = 1'b0;
                    err_d         = err_q | ~sif.bus_ack;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_REQ: begin
                bus_addr_d    = ptr_q;
                bus_rd_strb_d = 1'b1;
                rd_pend_d     = 1'b0;
                cnt_d         = CW'(TIMEOUT);
                state_d       = RD_WAIT;
            end
            RD_WAIT: begin
                if (sif.bus_ack || cnt_q == '0) begin
                    rd_data_d     = sif.bus_ack ? sif.bus_rd_data : RD_DEFAULT;
                    bus_rd_strb_d = 1'b0;
                    err_d         = err_q | ~sif.bus_ack;
                    state_d       = LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                if (rd_pend_q) begin
                    state_d = RD_REQ;
                end else begin
                    as_data_d  = rd_data_q;
                    as_dstrb_d = 1'b1;
                    loaded_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (consumed) begin
            loaded_d  = 1'b0;
            ptr_d     = ptr_d + 1'b1;
            rd_pend_d = 1'b1;
        end
        if (sif.as_dstrb_i) begin
            if (first_byte_q) begin
                ptr_d        = sif.as_data_i[ADDR_W-1:0];
                first_byte_d = 1'b0;
                rd_pend_d    = 1'b1;
            end else begin
                wr_data_d = sif.as_data_i;
                wr_pend_d = 1'b1;
                err_d     = err_d | wr_pend_q;
            end
        end
        if (sif.i2c_cmnd_strb_i) begin
            first_byte_d = 1'b1;
            err_d        = 1'b0;
            rd_pend_d    = 1'b1;
        end
    end

    // State and output registers; async reset drops any bus request immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            first_byte_q  <= 1'b0;
            loaded_q      <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            busy_q        <= 1'b0;
            ptr_q         <= '0;
            wr_data_q     <= '0;
            rd_data_q     <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            as_data_q     <= '0;
            as_dstrb_q    <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_wr_strb_q <= 1'b0;
            bus_rd_strb_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_byte_q  <= first_byte_d;
            loaded_q      <= loaded_d;
            wr_pend_q     <= wr_pend_d;
            rd_pend_q     <= rd_pend_d;
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            wr_data_q     <= wr_data_d;
            rd_data_q     <= rd_data_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            as_data_q     <= as_data_d;
            as_dstrb_q    <= as_dstrb_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_wr_strb_q <= bus_wr_strb_d;
            bus_rd_strb_q <= bus_rd_strb_d;
        end
    end

    assign sif.as_data_o   = as_data_q;
    assign sif.as_dstrb_o  = as_dstrb_q;
    assign sif.bus_addr    = bus_addr_q;
    assign sif.bus_wr_data = bus_wr_data_q;
    assign sif.bus_wr_strb = bus_wr_strb_q;
    assign sif.bus_rd_strb = bus_rd_strb_q;
    assign sif.ptr_o       = ptr_q;
    assign sif.err_o       = err_q;
endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// tb_i2c_slave_reg_ctrl: scoreboard bench with a register-bus responder and preload monitor
module tb_i2c_slave_reg_ctrl;
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int ack_dly = 2;
    int dly = 0;
    logic hold = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] exp_ld [$];
    wr_t exp_wr [$];

    i2c_slave_reg_ctrl_if #(.ADDR_W(8)) sif ();

    i2c_slave_reg_ctrl #(.ADDR_W(8), .TIMEOUT(255), .RD_DEFAULT(8'hFF)) dut (
        .clk(clk),
        .reset(reset),
        .sif(sif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sif.bus_wr_strb || sif.bus_rd_strb) begin
                total++;
                if (sif.bus_wr_strb && sif.bus_rd_strb) begin
                    bad++;
                    $display("FAIL strobe_excl wr=%b rd=%b required not both", sif.bus_wr_strb, sif.bus_rd_strb);
                end
            end
            if (sif.bus_ack) begin
                sif.bus_ack = 1'b0;
                dly = 0;
            end else if ((sif.bus_wr_strb || sif.bus_rd_strb) && !hold) begin
                dly++;
                if (dly >= ack_dly) begin
                    sif.bus_ack = 1'b1;
                    if (sif.bus_rd_strb) begin
                        sif.bus_rd_data = mem[sif.bus_addr];
                    end else begin
                        mem[sif.bus_addr] = sif.bus_wr_data;
                        total++;
                        if (exp_wr.size() == 0) begin
                            bad++;
                            $display("FAIL bus_write unexpected addr=%h data=%h", sif.bus_addr, sif.bus_wr_data);
                        end else begin
                            wr_t e;
                            e = exp_wr.pop_front();
                            if (sif.bus_addr !== e.a || sif.bus_wr_data !== e.d) begin
                                bad++;
                                $display("FAIL bus_write got addr=%h data=%h required addr=%h data=%h",
                                         sif.bus_addr, sif.bus_wr_data, e.a, e.d);
                            end
                        end
                    end
                end
            end else begin
                dly = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sif.as_dstrb_o) begin
                total++;
                if (exp_ld.size() == 0) begin
                    bad++;
                    $display("FAIL preload unexpected data=%h", sif.as_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_ld.pop_front();
                    if (sif.as_data_o !== e) begin
                        bad++;
                        $display("FAIL preload got=%h required=%h", sif.as_data_o, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic pulse_cmnd();
        @(negedge clk);
        sif.i2c_cmnd_strb_i = 1'b1;
        @(negedge clk);
        sif.i2c_cmnd_strb_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        sif.as_data_i = b;
        sif.as_dstrb_i = 1'b1;
        @(negedge clk);
        sif.as_dstrb_i = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        chk("rst_as_data_o", sif.as_data_o, 8'h00);
        chk("rst_as_dstrb_o", {7'd0, sif.as_dstrb_o}, 8'h00);
        chk("rst_bus_addr", sif.bus_addr, 8'h00);
        chk("rst_bus_wr_data", sif.bus_wr_data, 8'h00);
        chk("rst_strobes", {6'd0, sif.bus_wr_strb, sif.bus_rd_strb}, 8'h00);
        chk("rst_ptr_o", sif.ptr_o, 8'h00);
        chk("rst_err_o", {7'd0, sif.err_o}, 8'h00);
    endtask

    task automatic test_write();
        exp_ld.push_back(mem[8'h00]);
        pulse_cmnd();
        settle(15);
        exp_ld.push_back(mem[8'h10]);
        send_byte(8'h10);
        settle(15);
        exp_wr.push_back('{a: 8'h10, d: 8'hAA});
        send_byte(8'hAA);
        settle(15);
        exp_wr.push_back('{a: 8'h11, d: 8'hBB});
        send_byte(8'hBB);
        settle(15);
        chk("wr_ptr_o", sif.ptr_o, 8'h12);
        chk("wr_bus_addr", sif.bus_addr, 8'h11);
        chk("wr_err_o", {7'd0, sif.err_o}, 8'h00);
        chk("wr_mem11", mem[8'h11], 8'hBB);
    endtask

    task automatic test_read();
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC7;
        exp_ld.push_back(mem[8'h12]);
        pulse_cmnd();
        settle(15);
        exp_ld.push_back(8'h5A);
        send_byte(8'h20);
        settle(15);
        exp_ld.push_back(8'h5A);
        pulse_cmnd();
        settle(15);
        chk("rd_bus_addr", sif.bus_addr, 8'h20);
        chk("rd_ptr_o", sif.ptr_o, 8'h20);
        @(negedge clk);
        sif.as_busy_i = 1'b1;
        settle(3);
        exp_ld.push_back(8'hC7);
        sif.as_busy_i = 1'b0;
        settle(15);
        chk("rd_next_bus_addr", sif.bus_addr, 8'h21);
        chk("rd_next_ptr_o", sif.ptr_o, 8'h21);
        chk("rd_ld_drained", 8'(exp_ld.size()), 8'h00);
    endtask

    task automatic test_wrap();
        exp_ld.push_back(mem[8'h21]);
        pulse_cmnd();
        settle(15);
        exp_ld.push_back(mem[8'hFF]);
        send_byte(8'hFF);
        settle(15);
        exp_wr.push_back('{a: 8'hFF, d: 8'h11});
        send_byte(8'h11);
        settle(15);
        exp_wr.push_back('{a: 8'h00, d: 8'h22});
        send_byte(8'h22);
        settle(15);
        chk("wrap_ptr_o", sif.ptr_o, 8'h01);
        chk("wrap_mem00", mem[8'h00], 8'h22);
    endtask

    task automatic test_timeout();
        exp_ld.push_back(mem[8'h01]);
        pulse_cmnd();
        settle(15);
        hold = 1'b1;
        exp_ld.push_back(8'hFF);
        send_byte(8'h30);
        settle(200);
        chk("to_err_early", {7'd0, sif.err_o}, 8'h00);
        chk("to_rd_strb_held", {7'd0, sif.bus_rd_strb}, 8'h01);
        settle(100);
        chk("to_err_set", {7'd0, sif.err_o}, 8'h01);
        chk("to_rd_strb_drop", {7'd0, sif.bus_rd_strb}, 8'h00);
        chk("to_ptr_kept", sif.ptr_o, 8'h30);
        hold = 1'b0;
        exp_ld.push_back(mem[8'h30]);
        pulse_cmnd();
        chk("to_err_cleared", {7'd0, sif.err_o}, 8'h00);
        settle(15);
    endtask

    task automatic test_stale();
        mem[8'h30] = 8'hC3;
        mem[8'h40] = 8'h4D;
        ack_dly = 6;
        pulse_cmnd();
        settle(3);
        exp_ld.push_back(8'h4D);
        send_byte(8'h40);
        settle(25);
        ack_dly = 2;
        chk("stale_ptr_o", sif.ptr_o, 8'h40);
        chk("stale_bus_addr", sif.bus_addr, 8'h40);
        chk("stale_ld_drained", 8'(exp_ld.size()), 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [7:0] keep;
        mem[8'h60] = 8'h66;
        keep = 8'h66;
        exp_ld.push_back(mem[8'h40]);
        pulse_cmnd();
        settle(15);
        exp_ld.push_back(mem[8'h60]);
        send_byte(8'h60);
        settle(15);
        hold = 1'b1;
        send_byte(8'h77);
        settle(5);
        chk("rm_wr_strb_on", {7'd0, sif.bus_wr_strb}, 8'h01);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rm_wr_strb", {7'd0, sif.bus_wr_strb}, 8'h00);
        chk("rm_rd_strb", {7'd0, sif.bus_rd_strb}, 8'h00);
        chk("rm_bus_addr", sif.bus_addr, 8'h00);
        chk("rm_bus_wr_data", sif.bus_wr_data, 8'h00);
        chk("rm_ptr_o", sif.ptr_o, 8'h00);
        chk("rm_as_data_o", sif.as_data_o, 8'h00);
        chk("rm_as_dstrb_o", {7'd0, sif.as_dstrb_o}, 8'h00);
        chk("rm_err_o", {7'd0, sif.err_o}, 8'h00);
        hold = 1'b0;
        settle(3);
        reset = 1'b0;
        settle(10);
        chk("rm_mem_untouched", mem[8'h60], keep);
        chk("rm_no_rewrite", {7'd0, sif.bus_wr_strb}, 8'h00);
        chk("rm_wr_drained", 8'(exp_wr.size()), 8'h00);
        chk("rm_ld_drained", 8'(exp_ld.size()), 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        sif.as_data_i = 8'h00;
        sif.as_dstrb_i = 1'b0;
        sif.as_busy_i = 1'b0;
        sif.i2c_cmnd_strb_i = 1'b0;
        sif.bus_rd_data = 8'h00;
        sif.bus_ack = 1'b0;
        settle(3);
        test_reset();
        reset = 1'b0;
        settle(2);
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_stale();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
